// File: rtl/awb_pkg.sv
// Shared types and constants for the auto-white-balance gain controller.
// Includes the saturating accumulator helper used by the per-channel sums.
package awb_pkg;

    localparam int PW      = 10;
    localparam int RX_DW   = 4 * PW;
    localparam int ACC_W   = 32;
    localparam int HYST_SH = 4;

    localparam logic [2:0] GAIN_MIN   = 3'd1;
    localparam logic [2:0] GAIN_MAX   = 3'd7;
    localparam logic [2:0] GAIN_UNITY = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CALC  = 2'd2
    } awb_state_t;

    // Adds a two-pixel term to a channel sum, pinning at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [PW:0]      term);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(ACC_W - PW){1'b0}}, term};
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/awb_if.sv
// CSI-2 RX pixel stream as tapped from the line-buffer bridge path.
// The controller only observes it, so the slave side is inputs only.
interface awb_if;
    import awb_pkg::*;

    logic [3:0]       mipi_inst1_VSYNC;
    logic [3:0]       mipi_inst1_HSYNC;
    logic             mipi_inst1_VALID;
    logic [RX_DW-1:0] mipi_inst1_DATA;

    modport master (
        output mipi_inst1_VSYNC,
        output mipi_inst1_HSYNC,
        output mipi_inst1_VALID,
        output mipi_inst1_DATA
    );

    modport slave (
        input mipi_inst1_VSYNC,
        input mipi_inst1_HSYNC,
        input mipi_inst1_VALID,
        input mipi_inst1_DATA
    );
endinterface

// File: rtl/awb_gain_step.sv
// One channel of the CALC pipeline: latch sums/codes, multiply, then compare
// the weighted channel against the weighted green with hysteresis and clamp.
module awb_gain_step
    import awb_pkg::*;
(
    input  logic             mipi_pclk,
    input  logic             i_arstn,
    input  logic             en_lat,
    input  logic             en_mul,
    input  logic             en_cmp,
    input  logic [ACC_W-1:0] c_sum,
    input  logic [ACC_W-1:0] g_sum,
    input  logic [2:0]       c_code,
    input  logic [2:0]       g_code,
    output logic [2:0]       step_code
);

    logic [ACC_W-1:0] c_sum_r;
    logic [ACC_W-1:0] g_sum_r;
    logic [2:0]       c_code_r;
    logic [2:0]       g_code_r;
    logic [ACC_W+2:0] cw_r;
    logic [ACC_W+2:0] gw_r;
    logic             g_zero_r;
    logic [ACC_W+3:0] e_s;
    logic [ACC_W+3:0] g36_s;
    logic [ACC_W+3:0] h_s;
    logic [2:0]       next_code_s;

    // Operand latch and multiply stages.
    always_ff @(posedge mipi_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            c_sum_r  <= {ACC_W{1'b0}};
            g_sum_r  <= {ACC_W{1'b0}};
            c_code_r <= GAIN_UNITY;
            g_code_r <= GAIN_UNITY;
            cw_r     <= {(ACC_W + 3){1'b0}};
            gw_r     <= {(ACC_W + 3){1'b0}};
            g_zero_r <= 1'b1;
        end else begin
            if (en_lat) begin
                c_sum_r  <= c_sum;
                g_sum_r  <= g_sum;
                c_code_r <= c_code;
                g_code_r <= g_code;
            end
            if (en_mul) begin
                cw_r     <= {3'b000, c_sum_r} * {{ACC_W{1'b0}}, c_code_r};
                gw_r     <= {3'b000, g_sum_r} * {{ACC_W{1'b0}}, g_code_r};
                g_zero_r <= (g_sum_r == {ACC_W{1'b0}});
            end
        end
    end

    // Step decision; a frame without green carries no colour information, so hold.
    always_comb begin
        e_s         = {cw_r, 1'b0};
        g36_s       = {1'b0, gw_r};
        h_s         = g36_s >> HYST_SH;
        next_code_s = c_code_r;
        if (g_zero_r) begin
            next_code_s = c_code_r;
        end else if (e_s > g36_s + h_s) begin
            next_code_s = (c_code_r > GAIN_MIN) ? c_code_r - 3'd1 : GAIN_MIN;
        end else if (e_s + h_s < g36_s) begin
            next_code_s = (c_code_r < GAIN_MAX) ? c_code_r + 3'd1 : GAIN_MAX;
        end else begin
            next_code_s = c_code_r;
        end
    end

    // Compare stage result register.
    always_ff @(posedge mipi_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            step_code <= GAIN_UNITY;
        end else if (en_cmp) begin
            step_code <= next_code_s;
        end else begin
            step_code <= step_code;
        end
    end

endmodule

// File: rtl/awb_gain_ctrl.sv
// Auto-white-balance controller: per-frame Bayer sums from the RX stream and
// red/blue gain stepping, with new codes applied only at frame start.
module awb_gain_ctrl
    import awb_pkg::*;
(
    input  logic       mipi_pclk,
    input  logic       i_arstn,
    awb_if.slave       rx,
    input  logic       i_awb_en,
    input  logic [2:0] i_red_gain_man,
    input  logic [2:0] i_green_gain_man,
    input  logic [2:0] i_blue_gain_man,
    output logic [2:0] red_gain,
    output logic [2:0] green_gain,
    output logic [2:0] blue_gain,
    output logic       o_awb_busy
);

    logic             vs_r, hs_r, valid_r;
    logic [RX_DW-1:0] data_r;
    logic             vs_d_r, hs_d_r, fs_r, fe_r, par_r;
    logic [PW:0]      r_add_r, g_add_r, b_add_r;
    logic [PW:0]      r_add_s, g_add_s, b_add_s;
    logic [PW:0]      p31_s, p20_s;
    logic             fs_s, line_end_s, par_eff_s;
    logic [ACC_W-1:0] r_sum_r, g_sum_r, b_sum_r;
    awb_state_t       state_r, state_s;
    logic [1:0]       calc_cnt_r;
    logic             fs_pend_r;
    logic             en_lat_s, en_mul_s, en_cmp_s, en_wr_s;
    logic [2:0]       r_pend_r, b_pend_r, r_step_s, b_step_s;
    logic             unused_sync_s;

    assign unused_sync_s = ^{rx.mipi_inst1_VSYNC[3:1], rx.mipi_inst1_HSYNC[3:1]};

    // Input register stage.
    always_ff @(posedge mipi_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            vs_r    <= 1'b0;
            hs_r    <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= {RX_DW{1'b0}};
        end else begin
            vs_r    <= rx.mipi_inst1_VSYNC[0];
            hs_r    <= rx.mipi_inst1_HSYNC[0];
            valid_r <= rx.mipi_inst1_VALID;
            data_r  <= rx.mipi_inst1_DATA;
        end
    end

    assign fs_s       = vs_r & ~vs_d_r;
    assign line_end_s = ~hs_r & hs_d_r;
    assign par_eff_s  = fs_s ? 1'b0 : par_r;
    assign p31_s      = {1'b0, data_r[4*PW-1:3*PW]} + {1'b0, data_r[2*PW-1:PW]};
    assign p20_s      = {1'b0, data_r[3*PW-1:2*PW]} + {1'b0, data_r[PW-1:0]};

    // Route the two pixel pairs of a beat to channels by Bayer line parity.
    always_comb begin
        r_add_s = {(PW + 1){1'b0}};
        g_add_s = {(PW + 1){1'b0}};
        b_add_s = {(PW + 1){1'b0}};
        if (valid_r && hs_r) begin
            if (par_eff_s) begin
                r_add_s = p31_s;
                g_add_s = p20_s;
            end else begin
                g_add_s = p31_s;
                b_add_s = p20_s;
            end
        end else begin
            r_add_s = {(PW + 1){1'b0}};
        end
    end

    // Edge detect, line parity and per-beat channel terms.
    always_ff @(posedge mipi_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            vs_d_r  <= 1'b0;
            hs_d_r  <= 1'b0;
            fs_r    <= 1'b0;
            fe_r    <= 1'b0;
            par_r   <= 1'b0;
            r_add_r <= {(PW + 1){1'b0}};
            g_add_r <= {(PW + 1){1'b0}};
            b_add_r <= {(PW + 1){1'b0}};
        end else begin
            vs_d_r  <= vs_r;
            hs_d_r  <= hs_r;
            fs_r    <= fs_s;
            fe_r    <= ~vs_r & vs_d_r;
            par_r   <= fs_s ? 1'b0 : (par_r ^ line_end_s);
            r_add_r <= r_add_s;
            g_add_r <= g_add_s;
            b_add_r <= b_add_s;
        end
    end

    // Channel sums; a beat coinciding with frame start seeds the fresh sum.
    always_ff @(posedge mipi_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_sum_r <= {ACC_W{1'b0}};
            g_sum_r <= {ACC_W{1'b0}};
            b_sum_r <= {ACC_W{1'b0}};
        end else if (fs_r) begin
            r_sum_r <= {{(ACC_W - PW - 1){1'b0}}, r_add_r};
            g_sum_r <= {{(ACC_W - PW - 1){1'b0}}, g_add_r};
            b_sum_r <= {{(ACC_W - PW - 1){1'b0}}, b_add_r};
        end else begin
            r_sum_r <= sat_add(r_sum_r, r_add_r);
            g_sum_r <= sat_add(g_sum_r, g_add_r);
            b_sum_r <= sat_add(b_sum_r, b_add_r);
        end
    end

    // Next-state logic; a frame that starts mid-CALC is measured once CALC ends.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = fs_r ? ACCUM : IDLE;
            ACCUM:   state_s = fe_r ? CALC : ACCUM;
            CALC: begin
                if (calc_cnt_r == 2'd3) begin
                    state_s = (fs_pend_r || fs_r) ? ACCUM : IDLE;
                end else begin
                    state_s = CALC;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign en_lat_s = (state_r == CALC) && (calc_cnt_r == 2'd0);
    assign en_mul_s = (state_r == CALC) && (calc_cnt_r == 2'd1);
    assign en_cmp_s = (state_r == CALC) && (calc_cnt_r == 2'd2);
    assign en_wr_s  = (state_r == CALC) && (calc_cnt_r == 2'd3);

    // State register, CALC sequencing and busy flag.
    always_ff @(posedge mipi_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_r    <= IDLE;
            calc_cnt_r <= 2'd0;
            fs_pend_r  <= 1'b0;
            o_awb_busy <= 1'b0;
        end else begin
            state_r    <= state_s;
            calc_cnt_r <= (state_r == CALC) ? calc_cnt_r + 2'd1 : 2'd0;
            fs_pend_r  <= (state_r == CALC) ? (fs_pend_r | fs_r) : 1'b0;
            o_awb_busy <= (state_s == CALC);
        end
    end

    awb_gain_step u_step_r (
        .mipi_pclk (mipi_pclk),
        .i_arstn   (i_arstn),
        .en_lat    (en_lat_s),
        .en_mul    (en_mul_s),
        .en_cmp    (en_cmp_s),
        .c_sum     (r_sum_r),
        .g_sum     (g_sum_r),
        .c_code    (red_gain),
        .g_code    (green_gain),
        .step_code (r_step_s)
    );

    awb_gain_step u_step_b (
        .mipi_pclk (mipi_pclk),
        .i_arstn   (i_arstn),
        .en_lat    (en_lat_s),
        .en_mul    (en_mul_s),
        .en_cmp    (en_cmp_s),
        .c_sum     (b_sum_r),
        .g_sum     (g_sum_r),
        .c_code    (blue_gain),
        .g_code    (green_gain),
        .step_code (b_step_s)
    );

    // Pending codes and frame-start apply; manual mode seeds the pending codes.
    always_ff @(posedge mipi_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_pend_r   <= GAIN_UNITY;
            b_pend_r   <= GAIN_UNITY;
            red_gain   <= GAIN_UNITY;
            green_gain <= GAIN_UNITY;
            blue_gain  <= GAIN_UNITY;
        end else begin
            if (fs_r && !i_awb_en) begin
                r_pend_r <= i_red_gain_man;
                b_pend_r <= i_blue_gain_man;
            end else if (en_wr_s) begin
                r_pend_r <= r_step_s;
                b_pend_r <= b_step_s;
            end else begin
                r_pend_r <= r_pend_r;
                b_pend_r <= b_pend_r;
            end
            if (fs_r) begin
                red_gain   <= i_awb_en ? r_pend_r : i_red_gain_man;
                blue_gain  <= i_awb_en ? b_pend_r : i_blue_gain_man;
                green_gain <= i_green_gain_man;
            end
        end
    end

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// Directed bench for awb_gain_ctrl: a frame table for the steady stepping
// cases plus hand-built sequences for manual mode, timing, CALC overlap and reset.
module tb_awb_gain_ctrl;
    import awb_pkg::*;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       awb_en;
    logic [2:0] r_man, g_man, b_man;
    logic [2:0] red_gain, green_gain, blue_gain;
    logic       busy;

    int total = 0;
    int bad   = 0;
    longint er, eg, eb;

    awb_if bus();

    awb_gain_ctrl dut (
        .mipi_pclk        (clk),
        .i_arstn          (arstn),
        .rx               (bus),
        .i_awb_en         (awb_en),
        .i_red_gain_man   (r_man),
        .i_green_gain_man (g_man),
        .i_blue_gain_man  (b_man),
        .red_gain         (red_gain),
        .green_gain       (green_gain),
        .blue_gain        (blue_gain),
        .o_awb_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] rm, gm, bm;
        int         rv, gv, bv;
        logic [2:0] er, eg, eb;
    } vec_t;

    vec_t vt [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_gains(input string name, input logic [2:0] r, input logic [2:0] g,
                             input logic [2:0] b);
        chk({name, ".red"},   64'(red_gain),   64'(r));
        chk({name, ".green"}, 64'(green_gain), 64'(g));
        chk({name, ".blue"},  64'(blue_gain),  64'(b));
    endtask

    task automatic chk_sums(input string name);
        chk({name, ".rsum"}, 64'(dut.r_sum_r), 64'(er));
        chk({name, ".gsum"}, 64'(dut.g_sum_r), 64'(eg));
        chk({name, ".bsum"}, 64'(dut.b_sum_r), 64'(eb));
    endtask

    task automatic vs_set(input logic v);
        bus.mipi_inst1_VSYNC = {3'b101, v};
    endtask

    task automatic frame_begin();
        vs_set(1'b1);
        er = 0; eg = 0; eb = 0;
        repeat (4) tick();
    endtask

    task automatic frame_lines(input int rv, input int gv, input int bv, input int first, input int n);
        logic [9:0] pr, pg, pb;
        pr = rv[9:0]; pg = gv[9:0]; pb = bv[9:0];
        for (int l = first; l < first + n; l++) begin
            bus.mipi_inst1_HSYNC = 4'b0101;
            for (int k = 0; k < 16; k++) begin
                bus.mipi_inst1_VALID = 1'b1;
                if (l % 2 == 0) begin
                    bus.mipi_inst1_DATA = {pg, pb, pg, pb};
                    eg += 2 * gv; eb += 2 * bv;
                end else begin
                    bus.mipi_inst1_DATA = {pr, pg, pr, pg};
                    er += 2 * rv; eg += 2 * gv;
                end
                tick();
            end
            bus.mipi_inst1_VALID = 1'b0;
            bus.mipi_inst1_HSYNC = 4'b0100;
            repeat (3) tick();
        end
    endtask

    task automatic frame_end();
        vs_set(1'b0);
        repeat (8) tick();
    endtask

    initial begin
        // Frames are applied back to back; expected codes are those visible after each frame start.
        vt[0]  = '{1'b1, 3'd4, 3'd4, 3'd4,  256,  256, 256, 3'd4, 3'd4, 3'd4};
        vt[1]  = '{1'b1, 3'd4, 3'd4, 3'd4,  256,  256, 256, 3'd4, 3'd4, 3'd4};
        vt[2]  = '{1'b1, 3'd4, 3'd4, 3'd4,  512,  256, 256, 3'd4, 3'd4, 3'd4};
        vt[3]  = '{1'b1, 3'd4, 3'd4, 3'd4,  512,  256, 256, 3'd3, 3'd4, 3'd4};
        vt[4]  = '{1'b1, 3'd4, 3'd4, 3'd4,  512,  256, 256, 3'd2, 3'd4, 3'd4};
        vt[5]  = '{1'b1, 3'd4, 3'd4, 3'd4,  512,  256, 256, 3'd2, 3'd4, 3'd4};
        vt[6]  = '{1'b1, 3'd4, 3'd4, 3'd4, 1000, 1000,  16, 3'd2, 3'd4, 3'd4};
        vt[7]  = '{1'b1, 3'd4, 3'd4, 3'd4, 1000, 1000,  16, 3'd3, 3'd4, 3'd5};
        vt[8]  = '{1'b1, 3'd4, 3'd4, 3'd4, 1000, 1000,  16, 3'd4, 3'd4, 3'd6};
        vt[9]  = '{1'b1, 3'd4, 3'd4, 3'd4, 1000, 1000,  16, 3'd4, 3'd4, 3'd7};
        vt[10] = '{1'b1, 3'd4, 3'd4, 3'd4, 1000, 1000,  16, 3'd4, 3'd4, 3'd7};
        vt[11] = '{1'b1, 3'd4, 3'd4, 3'd4, 1000, 1000,  16, 3'd4, 3'd4, 3'd7};

        awb_en = 1'b1; r_man = 3'd4; g_man = 3'd4; b_man = 3'd4;
        bus.mipi_inst1_VSYNC = 4'b1010;
        bus.mipi_inst1_HSYNC = 4'b0100;
        bus.mipi_inst1_VALID = 1'b0;
        bus.mipi_inst1_DATA  = '0;
        repeat (3) tick();
        chk_gains("reset", 3'd4, 3'd4, 3'd4);
        chk("reset.busy", 64'(busy), 64'd0);
        arstn = 1'b1;

        // Line traffic without any VSYNC must not move anything.
        frame_lines(700, 100, 50, 0, 2);
        repeat (10) tick();
        chk_gains("novsync", 3'd4, 3'd4, 3'd4);
        chk("novsync.busy", 64'(busy), 64'd0);

        for (int i = 0; i < 12; i++) begin
            awb_en = vt[i].en; r_man = vt[i].rm; g_man = vt[i].gm; b_man = vt[i].bm;
            frame_begin();
            chk_gains($sformatf("vec%0d", i), vt[i].er, vt[i].eg, vt[i].eb);
            frame_lines(vt[i].rv, vt[i].gv, vt[i].bv, 0, 8);
            frame_end();
            chk_sums($sformatf("vec%0d", i));
        end

        // Manual mode: a mid-frame manual change waits for the next frame start.
        awb_en = 1'b0; r_man = 3'd5; g_man = 3'd4; b_man = 3'd4;
        frame_begin();
        chk_gains("man1", 3'd5, 3'd4, 3'd4);
        frame_lines(256, 256, 256, 0, 4);
        r_man = 3'd2;
        frame_lines(256, 256, 256, 4, 4);
        chk("man1.hold", 64'(red_gain), 64'd5);
        frame_end();
        chk("man1.after", 64'(red_gain), 64'd5);

        vs_set(1'b1);
        er = 0; eg = 0; eb = 0;
        tick();
        chk("man2.k0", 64'(red_gain), 64'd5);
        tick();
        chk("man2.k1", 64'(red_gain), 64'd5);
        tick();
        chk("man2.k2", 64'(red_gain), 64'd2);
        tick();
        awb_en = 1'b1;
        frame_lines(256, 256, 256, 0, 8);

        // Busy pulse: high from 2 to 5 cycles after VSYNC is sampled low.
        vs_set(1'b0);
        for (int n = 0; n <= 7; n++) begin
            tick();
            chk($sformatf("busy.k%0d", n), 64'(busy), (n >= 2 && n <= 5) ? 64'd1 : 64'd0);
        end
        chk_sums("man2");

        // Automatic mode resumes from the manual code 2 (grey frame steps it up).
        frame_begin();
        chk_gains("man3", 3'd3, 3'd4, 3'd4);
        frame_lines(256, 256, 256, 0, 4);

        // Reset mid-ACCUM.
        arstn = 1'b0;
        #1;
        chk_gains("rst", 3'd4, 3'd4, 3'd4);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.rsum", 64'(dut.r_sum_r), 64'd0);
        tick();
        arstn = 1'b1;
        tick();
        frame_lines(256, 256, 256, 4, 4);
        frame_end();
        chk_gains("rst.after", 3'd4, 3'd4, 3'd4);

        // Red-heavy frame, then a new frame starting while CALC is running.
        frame_begin();
        chk_gains("ovl1", 3'd4, 3'd4, 3'd4);
        frame_lines(512, 256, 256, 0, 8);
        vs_set(1'b0);
        tick();
        chk_sums("ovl1");
        tick();
        vs_set(1'b1);
        tick();
        chk("ovl.busy", 64'(busy), 64'd1);
        er = 0; eg = 0; eb = 0;
        repeat (3) tick();
        chk_gains("ovl2", 3'd4, 3'd4, 3'd4);
        frame_lines(512, 256, 256, 0, 8);
        vs_set(1'b0);
        repeat (3) tick();
        chk("ovl2.busy", 64'(busy), 64'd1);
        chk_sums("ovl2");
        repeat (6) tick();
        frame_begin();
        chk_gains("ovl3", 3'd3, 3'd4, 3'd4);
        frame_end();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
